// File: rtl/multiplier_if.sv
// Operand/result bundle for the packed SIMD multiplier: the master drives
// valid operands, the slave returns lane-wise products.
interface multiplier_if #(
    parameter int NUM_BITS = 512
);
    logic                in_valid;
    logic [NUM_BITS-1:0] dd;
    logic [NUM_BITS-1:0] aa;
    logic [NUM_BITS-1:0] product;
    logic                out_valid;

    modport master (
        output in_valid,
        output dd,
        output aa,
        input  product,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  dd,
        input  aa,
        output product,
        output out_valid
    );
endinterface

// File: rtl/multiplier.sv
// Packed SIMD unsigned multiplier: independent 8-bit lanes, one registered stage.
// Define MULTIPLIER_SAT_EN to saturate each lane to 0xFF instead of wrapping.
module multiplier #(
    parameter int NUM_BITS  = 512,
    parameter int LANE_BITS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    multiplier_if.slave  bus
);
    localparam int NUM_LANES = NUM_BITS / LANE_BITS;

    generate
        if (NUM_BITS <= 0 || (NUM_BITS % 8) != 0 || LANE_BITS != 8) begin : g_bad_cfg
            $error("multiplier: NUM_BITS must be a positive multiple of 8 and LANE_BITS must be 8");
        end
    endgenerate

`ifdef MULTIPLIER_SAT_EN
    function automatic logic [7:0] lane_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] full;
        full = {8'd0, a} * {8'd0, b};
        return (full[15:8] != 8'd0) ? 8'hFF : full[7:0];
    endfunction
`else
    function automatic logic [7:0] lane_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] low;
        // Product evaluated at 8-bit width, which is exactly modulo 256.
        low = a * b;
        return low;
    endfunction
`endif

    logic [NUM_BITS-1:0] product_d;
    logic [NUM_BITS-1:0] product_q;
    logic                out_valid_d;
    logic                out_valid_q;

    // Next-state: compute all lanes on valid input, otherwise hold the result.
    always_comb begin
        product_d   = product_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                product_d[k*LANE_BITS +: LANE_BITS] =
                    lane_mul(bus.dd[k*LANE_BITS +: LANE_BITS], bus.aa[k*LANE_BITS +: LANE_BITS]);
            end
            out_valid_d = 1'b1;
        end else begin
            product_d   = product_q;
            out_valid_d = 1'b0;
        end
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q   <= {NUM_BITS{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.product   = product_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed vector table, corner-case
// sequences, and randomized traffic against a lane-wise arithmetic model.
module tb_multiplier;
    localparam int NB = 512;
    localparam int NL = NB / 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multiplier_if #(.NUM_BITS(NB)) bus ();

    multiplier #(.NUM_BITS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [NB-1:0] dd;
        logic [NB-1:0] aa;
        logic [NB-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Reference lane result from plain integer arithmetic.
    function automatic int lane_ref(input int a, input int b);
        int p;
        p = a * b;
`ifdef MULTIPLIER_SAT_EN
        return (p > 255) ? 255 : p;
`else
        return p % 256;
`endif
    endfunction

    function automatic logic [NB-1:0] model(input logic [NB-1:0] d, input logic [NB-1:0] a);
        logic [NB-1:0] r;
        int            x;
        int            y;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            x = int'(d[k*8 +: 8]);
            y = int'(a[k*8 +: 8]);
            r[k*8 +: 8] = 8'(lane_ref(x, y));
        end
        return r;
    endfunction

    task automatic check_bus(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s product act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s out_valid act=%b exp=%b", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, then sample just after the capturing edge.
    task automatic step(input logic v, input logic [NB-1:0] d, input logic [NB-1:0] a);
        @(negedge clk);
        bus.in_valid = v;
        bus.dd       = d;
        bus.aa       = a;
        @(posedge clk);
        #1;
    endtask

    logic [NB-1:0] d_v;
    logic [NB-1:0] a_v;
    logic [NB-1:0] e_v;
    logic [NB-1:0] held;
    logic [NB-1:0] seq_d[3];
    logic [NB-1:0] seq_a[3];
    logic [NB-1:0] seq_e[3];
    logic          v_r;

    initial begin
        checks       = 0;
        failures     = 0;
        bus.in_valid = 1'b0;
        bus.dd       = '0;
        bus.aa       = '0;
        rst_n        = 1'b0;
        #12;
        check_bus("reset_product", bus.product, '0);
        check_bit("reset_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, '0);
        check_bus("post_release_product", bus.product, '0);
        check_bit("post_release_valid", bus.out_valid, 1'b0);

        // Directed vector table.
        d_v = '0; a_v = '0; e_v = '0;
        d_v[7:0] = 8'h03; a_v[7:0] = 8'h03; e_v[7:0] = 8'h09;
        vecs.push_back('{"lane0_3x3", d_v, a_v, e_v});
        d_v = '0; a_v = '0; e_v = '0;
        d_v[311:304] = 8'hFF; a_v[311:304] = 8'h02;
`ifdef MULTIPLIER_SAT_EN
        e_v[311:304] = 8'hFF;
`else
        e_v[311:304] = 8'hFE;
`endif
        vecs.push_back('{"lane38_ffx2", d_v, a_v, e_v});
        d_v = '0; a_v = '0; e_v = '0;
        d_v[511:504] = 8'h33; a_v[511:504] = 8'h05; e_v[511:504] = 8'hFF;
        vecs.push_back('{"lane63_33x5", d_v, a_v, e_v});
        d_v = '1; a_v = '1;
        for (int k = 0; k < NL; k++) begin
`ifdef MULTIPLIER_SAT_EN
            e_v[k*8 +: 8] = 8'hFF;
`else
            e_v[k*8 +: 8] = 8'h01;
`endif
        end
        vecs.push_back('{"all_ones", d_v, a_v, e_v});
        d_v = '1; a_v = '0; e_v = '0;
        vecs.push_back('{"zero_operand", d_v, a_v, e_v});
        for (int k = 0; k < NL; k++) begin
            d_v = '0; a_v = '0; e_v = '0;
            d_v[k*8 +: 8] = 8'h03; a_v[k*8 +: 8] = 8'h03; e_v[k*8 +: 8] = 8'h09;
            vecs.push_back('{$sformatf("walk_lane%0d", k), d_v, a_v, e_v});
        end

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].dd, vecs[i].aa);
            check_bus(vecs[i].name, bus.product, vecs[i].exp);
            check_bit(vecs[i].name, bus.out_valid, 1'b1);
        end

        // Handshake: three back-to-back results, then hold.
        for (int i = 0; i < 3; i++) begin
            seq_d[i] = '0; seq_a[i] = '0; seq_e[i] = '0;
            seq_d[i][15:0] = 16'(16'h1111 * (i + 1));
            seq_a[i][15:0] = 16'(16'h0302 + i);
        end
        seq_e[0][7:0] = 8'h22; seq_e[0][15:8] = 8'h33;
        seq_e[1][7:0] = 8'h66; seq_e[1][15:8] = 8'h66;
        seq_e[2][7:0] = 8'hCC; seq_e[2][15:8] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq_d[i], seq_a[i]);
            check_bus($sformatf("burst%0d", i), bus.product, seq_e[i]);
            check_bit($sformatf("burst%0d", i), bus.out_valid, 1'b1);
        end
        step(1'b0, '1, '1);
        check_bus("burst_hold", bus.product, seq_e[2]);
        check_bit("burst_hold", bus.out_valid, 1'b0);
        step(1'b0, '0, '0);
        check_bus("burst_hold2", bus.product, seq_e[2]);

        // Asynchronous reset mid-cycle with a nonzero result held.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bus("async_reset_product", bus.product, '0);
        check_bit("async_reset_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        check_bus("reset_held", bus.product, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '1, '1);
        check_bus("release_idle_product", bus.product, '0);
        check_bit("release_idle_valid", bus.out_valid, 1'b0);

        // In-flight input discarded by reset before its capture edge.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.dd = '1; bus.aa = '1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_bus("inflight_discard", bus.product, '0);
        check_bit("inflight_discard", bus.out_valid, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic against the lane model; idle cycles must hold.
        held = '0;
        for (int n = 0; n < 200; n++) begin
            for (int w = 0; w < NB / 32; w++) begin
                d_v[w*32 +: 32] = $urandom;
                a_v[w*32 +: 32] = $urandom;
            end
            if ((n % 7) == 0) begin
                d_v[($urandom_range(NL - 1))*8 +: 8] = 8'h00;
                a_v[($urandom_range(NL - 1))*8 +: 8] = 8'hFF;
            end
            v_r = ($urandom_range(3) != 0);
            if (v_r) held = model(d_v, a_v);
            step(v_r, d_v, a_v);
            check_bus($sformatf("rand%0d", n), bus.product, held);
            check_bit($sformatf("rand%0d", n), bus.out_valid, v_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
